sprite_line_scheduler: RTL



---
 rtl/snake_draw_pkg.sv | 36 +++
 rtl/sprite_line_scan.sv | 107 ++++++++++
 rtl/sprite_line_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/snake_draw_pkg.sv
`default_nettype none
// snake_draw_pkg: shared sizes, layer encodings and the per-line hit-list entry for the snake renderer.
// Revision: 1.0
package snake_draw_pkg;

  localparam int SEG_MAX    = 23;
  localparam int LIST_DEPTH = 8;
  localparam int SPR        = 32;

  localparam logic [2:0] LAYER_GRASS = 3'd0;
  localparam logic [2:0] LAYER_APPLE = 3'd1;
  localparam logic [2:0] LAYER_HEAD  = 3'd2;
  localparam logic [2:0] LAYER_BODY  = 3'd3;
  localparam logic [2:0] LAYER_BLANK = 3'd4;

  typedef struct packed {
    logic        is_head;
    logic [10:0] x;
    logic [4:0]  dy;
  } line_entry_t;

  localparam int ENTRY_W = $bits(line_entry_t);

  // Compared in 12 bits so a sprite near 2047 runs off the edge instead of wrapping to 0.
  function automatic logic in_window(input logic [10:0] origin, input logic [10:0] pos);
    logic [11:0] lo;
    logic [11:0] hi;
    logic [11:0] p;
    lo = {1'b0, origin};
    hi = lo + 12'(SPR);
    p  = {1'b0, pos};
    return (p >= lo) && (p < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_line_scan.sv
`default_nettype none
// sprite_line_scan: walks the snake segments during hblank, building the hit list for the next line.
// Revision: 1.0
module sprite_line_scan
  import snake_draw_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            line_start,
  input  logic [10:0]                     next_y,
  input  logic [11*SEG_MAX-1:0]           snakepos_x,
  input  logic [11*SEG_MAX-1:0]           snakepos_y,
  input  logic [5:0]                      length,
  output logic                            scan_busy,
  output logic                            line_overflow,
  output logic [ENTRY_W*LIST_DEPTH-1:0]   active_list,
  output logic [LIST_DEPTH-1:0]           active_valid
);

  localparam int CNT_W = $clog2(LIST_DEPTH + 1);
  localparam int IDX_W = $clog2(LIST_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(LIST_DEPTH);
  localparam logic [5:0]       SEG_MAX_C = 6'(SEG_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]                   state;
  logic [10:0]                  line_y;
  logic [4:0]                   k;
  logic [CNT_W-1:0]             count;
  line_entry_t [LIST_DEPTH-1:0] build_list;
  logic [LIST_DEPTH-1:0]        build_valid;

  logic [5:0]  live;
  logic [10:0] seg_x;
  logic [10:0] seg_y;
  logic [4:0]  dy;
  logic        hit;
  logic        last_seg;
  line_entry_t new_entry;

  always_comb begin
    live      = (length > SEG_MAX_C) ? SEG_MAX_C : length;
    seg_x     = snakepos_x[k*11 +: 11];
    seg_y     = snakepos_y[k*11 +: 11];
    dy        = line_y[4:0] - seg_y[4:0];
    // With zero live segments the single SCAN cycle records nothing.
    hit       = ({1'b0, k} < live) && in_window(seg_y, line_y);
    last_seg  = ({1'b0, k} + 6'd1) >= live;
    new_entry.is_head = (k == 5'd0);
    new_entry.x       = seg_x;
    new_entry.dy      = dy;
    for (int i = 0; i < LIST_DEPTH; i++) begin
      build_valid[i] = CNT_W'(i) < count;
    end
  end

  assign scan_busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      line_y        <= '0;
      k             <= '0;
      count         <= '0;
      line_overflow <= 1'b0;
      build_list    <= '0;
      active_list   <= '0;
      active_valid  <= '0;
    end else if (line_start) begin
      // A new line_start always restarts the walk; the active list keeps the last committed line.
      state         <= S_SCAN;
      line_y        <= next_y;
      k             <= '0;
      count         <= '0;
      line_overflow <= 1'b0;
    end else begin
      case (state)
        S_SCAN: begin
          if (hit) begin
            if (count < DEPTH_C) begin
              build_list[count[IDX_W-1:0]] <= new_entry;
              count                        <= count + 1'b1;
            end else begin
              line_overflow <= 1'b1;
            end
          end
          if (last_seg) begin
            state <= S_COMMIT;
          end else begin
            k <= k + 5'd1;
          end
        end
        S_COMMIT: begin
          active_list  <= build_list;
          active_valid <= build_valid;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
`default_nettype none
// sprite_line_scheduler: per-line sprite list plus a two-stage pixel pipeline choosing the layer and ROM addresses.
// Revision: 1.0
module sprite_line_scheduler
  import snake_draw_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic [10:0]           next_y,
  input  logic [11*SEG_MAX-1:0] snakepos_x,
  input  logic [11*SEG_MAX-1:0] snakepos_y,
  input  logic [5:0]            length,
  input  logic [10:0]           applepos_x,
  input  logic [10:0]           applepos_y,
  input  logic                  win,
  input  logic                  lose,
  input  logic                  pix_valid,
  input  logic [10:0]           curr_x,
  input  logic [10:0]           curr_y,
  output logic                  scan_busy,
  output logic                  line_overflow,
  output logic [9:0]            addr_apple,
  output logic [9:0]            addr_head,
  output logic [9:0]            addr_body,
  output logic [9:0]            addr_grass,
  output logic [2:0]            layer_sel,
  output logic                  layer_valid,
  output logic                  game_end
);

  logic [ENTRY_W*LIST_DEPTH-1:0] active_list;
  logic [LIST_DEPTH-1:0]         active_valid;

  sprite_line_scan u_scan (
    .clk           (clk),
    .rst           (rst),
    .line_start    (line_start),
    .next_y        (next_y),
    .snakepos_x    (snakepos_x),
    .snakepos_y    (snakepos_y),
    .length        (length),
    .scan_busy     (scan_busy),
    .line_overflow (line_overflow),
    .active_list   (active_list),
    .active_valid  (active_valid)
  );

  logic        apple_hit;
  logic        head_hit;
  logic        body_hit;
  line_entry_t entry;
  line_entry_t head_e;
  line_entry_t body_e;
  logic [4:0]  apple_dx;
  logic [4:0]  apple_dy;
  logic [4:0]  head_dx;
  logic [4:0]  body_dx;
  logic [2:0]  win_layer;

  always_comb begin
    apple_hit = in_window(applepos_x, curr_x) && in_window(applepos_y, curr_y);
    head_hit  = 1'b0;
    body_hit  = 1'b0;
    entry     = '0;
    head_e    = '0;
    body_e    = '0;
    // Walk from the top index down so the lowest-index body match is the one left standing.
    for (int i = LIST_DEPTH - 1; i >= 0; i--) begin
      entry = active_list[i*ENTRY_W +: ENTRY_W];
      if (active_valid[i] && in_window(entry.x, curr_x)) begin
        if (entry.is_head) begin
          head_hit = 1'b1;
          head_e   = entry;
        end else begin
          body_hit = 1'b1;
          body_e   = entry;
        end
      end
    end
    apple_dx = curr_x[4:0] - applepos_x[4:0];
    apple_dy = curr_y[4:0] - applepos_y[4:0];
    head_dx  = curr_x[4:0] - head_e.x[4:0];
    body_dx  = curr_x[4:0] - body_e.x[4:0];
    if (game_end)       win_layer = LAYER_BLANK;
    else if (apple_hit) win_layer = LAYER_APPLE;
    else if (head_hit)  win_layer = LAYER_HEAD;
    else if (body_hit)  win_layer = LAYER_BODY;
    else                win_layer = LAYER_GRASS;
  end

  logic [2:0] s1_layer;
  logic       s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_end    <= 1'b0;
      s1_layer    <= LAYER_GRASS;
      s1_valid    <= 1'b0;
      layer_sel   <= LAYER_GRASS;
      layer_valid <= 1'b0;
      addr_apple  <= '0;
      addr_head   <= '0;
      addr_body   <= '0;
      addr_grass  <= '0;
    end else begin
      if (frame_start) begin
        game_end <= win | lose;
      end
      s1_valid    <= pix_valid;
      layer_sel   <= s1_layer;
      layer_valid <= s1_valid;
      if (pix_valid) begin
        s1_layer <= win_layer;
        // Only the winning layer's ROM address moves; the others keep their last value.
        case (win_layer)
          LAYER_APPLE: addr_apple <= {apple_dy, apple_dx};
          LAYER_HEAD:  addr_head  <= {head_e.dy, head_dx};
          LAYER_BODY:  addr_body  <= {body_e.dy, body_dx};
          LAYER_GRASS: addr_grass <= {curr_y[4:0], curr_x[4:0]};
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
